complete_arbiter: RTL and testbench
===================================

COMPLETE_ARBITER -- requirements
Module: complete_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: FIFO_DEPTH, 2, entries per requester buffer (fixed at 2; other values unsupported).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 fu_valid  input  4  per-requester completion valid (bit0 ALU0, bit1 ALU1, bit2 MUL, bit3 LSU).
REQ-006 fu_pc  input  4x32  per-requester completing instruction PC.
REQ-007 fu_data  input  4x32  per-requester destination register result.
REQ-008 fu_ready  output  4  per-requester buffer can accept (registered).
REQ-009 rob_stall  input  1  reorder buffer cannot accept completions this cycle.
REQ-010 flush  input  1  discard all buffered completions.
REQ-011 complete_valid_0/1/2  output  1 each  completion port k carries a valid result.
REQ-012 complete_pc_0/1/2  output  32 each  PC for completion port k.
REQ-013 new_dr_data_0/1/2  output  32 each  result data for completion port k.

Function
REQ-014 Each requester SHALL own a FIFO_DEPTH-entry FIFO of {pc, data} with a 2-bit occupancy count.
REQ-015 Push: fu_valid[i] && fu_ready[i] at a rising edge SHALL write {fu_pc[i], fu_data[i]} to FIFO i.
REQ-016 fu_ready[i] SHALL equal (count_i < 2) as registered after the edge; it SHALL NOT look ahead to a same-cycle pop.
REQ-017 fu_valid[i] while fu_ready[i]=0 SHALL be ignored; the requester holds its data.
REQ-018 Eligible set: requesters whose FIFO is non-empty at the start of the cycle.
REQ-019 Grant: with rob_stall=0 and flush=0, up to 3 eligible requesters SHALL be granted per cycle, scanning modulo 4 from rr_ptr: the first eligible to port 0, the second to port 1, the third to port 2.
REQ-020 Port fill SHALL be dense: port k is valid only if ports 0..k-1 are valid in the same cycle.
REQ-021 Each granted FIFO SHALL pop its head at the edge; at most one pop per FIFO per cycle.
REQ-022 Outputs SHALL be registered: grants computed in cycle N appear on complete_* after edge N; minimum latency from push edge to output is 1 cycle; no combinational bypass from fu_* to complete_*.
REQ-023 rr_ptr (2 bits) SHALL advance to (last granted index + 1) mod 4 after any grant and hold when nothing is granted.
REQ-024 rob_stall=1: no grants and no pops; complete_valid_* SHALL be 0 after the edge; pushes continue.
REQ-025 A simultaneous push and pop on FIFO i SHALL leave count_i unchanged and preserve FIFO order.
REQ-026 flush=1: all counts and FIFO pointers SHALL clear, complete_valid_* SHALL be 0 after the edge, a same-cycle push SHALL be dropped, and rr_ptr SHALL hold.
REQ-027 flush has priority over rob_stall; rst has priority over flush.
REQ-028 When complete_valid_k=0, complete_pc_k and new_dr_data_k SHALL be 0.
REQ-029 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Within one requester, completions SHALL exit in push order.

Reset
REQ-031 On rst=1 at an edge, the block SHALL clear all FIFO counts and pointers, set rr_ptr=0, set complete_valid_*=0, complete_pc_*=0, new_dr_data_*=0, and set fu_ready=4'b1111 after the edge.
REQ-032 Reset asserted mid-operation SHALL discard all buffered entries with no completion emitted in the reset cycle.
REQ-033 FIFO storage contents need not be cleared by reset.

Verification
REQ-034 Four requesters push PCs 0x100/0x200/0x300/0x400 in one cycle with rr_ptr=0 -> next cycle ports 0/1/2 carry 0x100/0x200/0x300 and rr_ptr=3; the following cycle port 0 carries 0x400 and ports 1/2 are invalid.
REQ-035 ALU0 pushes on 3 consecutive cycles with no pops (rob_stall=1) -> fu_ready[0]=0 after the second push, the third value is held by the requester, and no complete_valid is asserted.
REQ-036 Full FIFO 0 (0xA0, 0xA4) with rob_stall released and a push of 0xA8 offered -> 0xA0 emitted first, 0xA8 accepted only after fu_ready[0] returns to 1, and output order is 0xA0, 0xA4, 0xA8.
REQ-037 Only LSU holds an entry and rr_ptr=1 -> port 0 carries the LSU entry, ports 1/2 are invalid, and rr_ptr=0 afterwards.
REQ-038 Flush asserted with 6 buffered entries and a concurrent push -> all complete_valid=0 after the edge, fu_ready=1111, and no stale entry is emitted later.
REQ-039 rst asserted for 1 cycle while outputs are valid -> all outputs 0 and fu_ready=1111 after the edge.

Source files
------------

// File: rtl/complete_arbiter.sv
// Completion arbiter: per-FU two-entry buffers drained round-robin onto three
// dense, registered completion ports feeding the reorder buffer.
module complete_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       fu_valid,
  input  logic [3:0][31:0] fu_pc,
  input  logic [3:0][31:0] fu_data,
  output logic [3:0]       fu_ready,
  input  logic             rob_stall,
  input  logic             flush,
  output logic             complete_valid_0,
  output logic             complete_valid_1,
  output logic             complete_valid_2,
  output logic [31:0]      complete_pc_0,
  output logic [31:0]      complete_pc_1,
  output logic [31:0]      complete_pc_2,
  output logic [31:0]      new_dr_data_0,
  output logic [31:0]      new_dr_data_1,
  output logic [31:0]      new_dr_data_2
);
  localparam int unsigned NUM_FU    = 4;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned IDX_W     = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t           mem       [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr    [NUM_FU];
  logic [PTR_W-1:0] wr_ptr    [NUM_FU];
  logic [CNT_W-1:0] count     [NUM_FU];
  logic [CNT_W-1:0] count_nxt [NUM_FU];
  logic [IDX_W-1:0] rr_ptr;

  logic [NUM_FU-1:0]    push;
  logic [NUM_FU-1:0]    pop;
  logic [NUM_FU-1:0]    gnt;
  logic [NUM_PORTS-1:0] port_vld;
  logic [IDX_W-1:0]     port_idx [NUM_PORTS];
  logic [IDX_W-1:0]     last_idx;
  logic [IDX_W-1:0]     scan_idx;
  logic [1:0]           n_gnt;

  logic [NUM_PORTS-1:0] out_vld;
  entry_t               out_ent [NUM_PORTS];

  // Round-robin scan from rr_ptr; the i-th non-empty FIFO found fills port i.
  always_comb begin
    gnt      = '0;
    port_vld = '0;
    last_idx = rr_ptr;
    scan_idx = rr_ptr;
    n_gnt    = '0;
    for (int k = 0; k < NUM_PORTS; k++) port_idx[k] = '0;
    for (int o = 0; o < NUM_FU; o++) begin
      scan_idx = rr_ptr + IDX_W'(o);
      if ((count[scan_idx] != '0) && (n_gnt < 2'(NUM_PORTS))) begin
        port_idx[n_gnt] = scan_idx;
        port_vld[n_gnt] = 1'b1;
        gnt[scan_idx]   = 1'b1;
        last_idx        = scan_idx;
        n_gnt           = n_gnt + 2'd1;
      end
    end
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      push[i]      = fu_valid[i] & fu_ready[i];
      pop[i]       = gnt[i] & ~rob_stall;
      count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // Payload storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!rst && !flush && push[i]) begin
        mem[i][wr_ptr[i]] <= {fu_pc[i], fu_data[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      fu_ready <= '1;
      out_vld  <= '0;
      for (int k = 0; k < NUM_PORTS; k++) out_ent[k] <= '0;
      if (rst) rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i]    <= count_nxt[i];
        fu_ready[i] <= (count_nxt[i] < CNT_W'(FIFO_DEPTH));
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        out_vld[k] <= port_vld[k] & ~rob_stall;
        out_ent[k] <= (port_vld[k] && !rob_stall) ?
                      mem[port_idx[k]][rd_ptr[port_idx[k]]] : '0;
      end
      if (!rob_stall && port_vld[0]) rr_ptr <= last_idx + IDX_W'(1);
    end
  end

  assign complete_valid_0 = out_vld[0];
  assign complete_valid_1 = out_vld[1];
  assign complete_valid_2 = out_vld[2];
  assign complete_pc_0    = out_ent[0].pc;
  assign complete_pc_1    = out_ent[1].pc;
  assign complete_pc_2    = out_ent[2].pc;
  assign new_dr_data_0    = out_ent[0].data;
  assign new_dr_data_1    = out_ent[1].data;
  assign new_dr_data_2    = out_ent[2].data;

endmodule

// File: tb/tb_complete_arbiter.sv
// Bench for complete_arbiter: directed vector table, hand sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_complete_arbiter;
  localparam logic [31:0] DMASK = 32'h5A5A_0000;

  logic             clk;
  logic             rst;
  logic [3:0]       fu_valid;
  logic [3:0][31:0] fu_pc;
  logic [3:0][31:0] fu_data;
  logic [3:0]       fu_ready;
  logic             rob_stall;
  logic             flush;
  logic             complete_valid_0, complete_valid_1, complete_valid_2;
  logic [31:0]      complete_pc_0, complete_pc_1, complete_pc_2;
  logic [31:0]      new_dr_data_0, new_dr_data_1, new_dr_data_2;

  complete_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_pc(fu_pc), .fu_data(fu_data),
    .fu_ready(fu_ready), .rob_stall(rob_stall), .flush(flush),
    .complete_valid_0(complete_valid_0), .complete_valid_1(complete_valid_1),
    .complete_valid_2(complete_valid_2),
    .complete_pc_0(complete_pc_0), .complete_pc_1(complete_pc_1),
    .complete_pc_2(complete_pc_2),
    .new_dr_data_0(new_dr_data_0), .new_dr_data_1(new_dr_data_1),
    .new_dr_data_2(new_dr_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [64:0] port_of(input int k);
    case (k)
      0:       return {complete_valid_0, complete_pc_0, new_dr_data_0};
      1:       return {complete_valid_1, complete_pc_1, new_dr_data_1};
      default: return {complete_valid_2, complete_pc_2, new_dr_data_2};
    endcase
  endfunction

  // Reference model: one queue of {pc,data} per requester.
  logic [63:0] mq [4][$];
  int          rr_m = 0;
  logic [3:0]  m_ready = 4'hF;
  logic [2:0]  m_vld = '0;
  logic [31:0] m_pc [3];
  logic [31:0] m_data [3];

  function automatic void model_step();
    logic [3:0] elig;
    int n, last;
    m_vld = '0;
    for (int k = 0; k < 3; k++) begin m_pc[k] = '0; m_data[k] = '0; end
    if (rst || flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      if (rst) rr_m = 0;
      m_ready = 4'hF;
      return;
    end
    for (int i = 0; i < 4; i++) elig[i] = (mq[i].size() > 0);
    if (!rob_stall) begin
      n = 0;
      last = 0;
      for (int o = 0; o < 4; o++) begin
        int i;
        i = (rr_m + o) % 4;
        if (elig[i] && n < 3) begin
          logic [63:0] e;
          e = mq[i].pop_front();
          m_vld[n]  = 1'b1;
          m_pc[n]   = e[63:32];
          m_data[n] = e[31:0];
          n++;
          last = i;
        end
      end
      if (n > 0) rr_m = (last + 1) % 4;
    end
    for (int i = 0; i < 4; i++)
      if (fu_valid[i] && m_ready[i]) mq[i].push_back({fu_pc[i], fu_data[i]});
    for (int i = 0; i < 4; i++) m_ready[i] = (mq[i].size() < 2);
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model ready", 128'(fu_ready), 128'(m_ready));
    for (int k = 0; k < 3; k++)
      check($sformatf("model port%0d", k), 128'(port_of(k)),
            128'({m_vld[k], m_pc[k], m_data[k]}));
  endtask

  typedef struct {
    logic        r, f, s;
    logic [3:0]  val;
    logic [31:0] base;
    logic [3:0]  e_ready;
    logic [2:0]  e_vld;
    logic [31:0] e_pc0, e_pc1, e_pc2;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic s,
                              input logic [3:0] val, input logic [31:0] base,
                              input logic [3:0] er, input logic [2:0] ev,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2);
    vec_t v;
    v.r = r; v.f = f; v.s = s; v.val = val; v.base = base;
    v.e_ready = er; v.e_vld = ev; v.e_pc0 = p0; v.e_pc1 = p1; v.e_pc2 = p2;
    return v;
  endfunction

  // Requester i presents pc = base + i*0x100 and data = pc ^ DMASK.
  task automatic run_vec(input string tag, input vec_t v);
    logic [31:0] ep;
    rst = v.r; flush = v.f; rob_stall = v.s; fu_valid = v.val;
    for (int i = 0; i < 4; i++) begin
      fu_pc[i]   = v.base + 32'(i) * 32'h100;
      fu_data[i] = fu_pc[i] ^ DMASK;
    end
    step();
    check({tag, " ready"}, 128'(fu_ready), 128'(v.e_ready));
    for (int k = 0; k < 3; k++) begin
      ep = (k == 0) ? v.e_pc0 : (k == 1) ? v.e_pc1 : v.e_pc2;
      check($sformatf("%s port%0d", tag, k), 128'(port_of(k)),
            v.e_vld[k] ? 128'({1'b1, ep, ep ^ DMASK}) : 128'(0));
    end
  endtask

  vec_t tbl [15];

  initial begin
    rst = 1'b1; flush = 1'b0; rob_stall = 1'b0; fu_valid = '0;
    fu_pc = '0; fu_data = '0;
    for (int k = 0; k < 3; k++) begin m_pc[k] = '0; m_data[k] = '0; end

    tbl[0]  = mk(1, 0, 0, 4'h0, 32'h0,    4'hF, 3'b000, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 4'hF, 32'h100,  4'hF, 3'b000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b111, 32'h100, 32'h200, 32'h300);
    tbl[3]  = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b001, 32'h400, 0, 0);
    tbl[4]  = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b000, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 4'h1, 32'h500,  4'hF, 3'b000, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 4'h8, 32'h600,  4'hF, 3'b001, 32'h500, 0, 0);
    tbl[7]  = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b001, 32'h900, 0, 0);
    tbl[8]  = mk(0, 0, 0, 4'h9, 32'hA00,  4'hF, 3'b000, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b011, 32'hA00, 32'hD00, 0);
    tbl[10] = mk(0, 0, 1, 4'hF, 32'h1000, 4'hF, 3'b000, 0, 0, 0);
    tbl[11] = mk(0, 0, 1, 4'h3, 32'h2000, 4'hC, 3'b000, 0, 0, 0);
    tbl[12] = mk(0, 1, 1, 4'hF, 32'h3000, 4'hF, 3'b000, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b000, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 4'h0, 32'h0,    4'hF, 3'b000, 0, 0, 0);

    for (int v = 0; v < 15; v++) run_vec($sformatf("tbl%0d", v), tbl[v]);

    // ALU0 fills under stall, third value held, then drains in push order.
    run_vec("hold1", mk(0, 0, 1, 4'h1, 32'hA0, 4'hF, 3'b000, 0, 0, 0));
    run_vec("hold2", mk(0, 0, 1, 4'h1, 32'hA4, 4'hE, 3'b000, 0, 0, 0));
    run_vec("hold3", mk(0, 0, 1, 4'h1, 32'hA8, 4'hE, 3'b000, 0, 0, 0));
    run_vec("drain1", mk(0, 0, 0, 4'h1, 32'hA8, 4'hF, 3'b001, 32'hA0, 0, 0));
    run_vec("drain2", mk(0, 0, 0, 4'h1, 32'hA8, 4'hF, 3'b001, 32'hA4, 0, 0));
    run_vec("drain3", mk(0, 0, 0, 4'h0, 32'h0,  4'hF, 3'b001, 32'hA8, 0, 0));
    run_vec("drain4", mk(0, 0, 0, 4'h0, 32'h0,  4'hF, 3'b000, 0, 0, 0));

    // Reset while completions are in flight.
    run_vec("rst1", mk(0, 0, 0, 4'hF, 32'h100, 4'hF, 3'b000, 0, 0, 0));
    run_vec("rst2", mk(0, 0, 0, 4'h0, 32'h0,   4'hF, 3'b111, 32'h200, 32'h300, 32'h400));
    run_vec("rst3", mk(1, 0, 0, 4'hF, 32'h500, 4'hF, 3'b000, 0, 0, 0));
    run_vec("rst4", mk(0, 0, 0, 4'h0, 32'h0,   4'hF, 3'b000, 0, 0, 0));

    for (int c = 0; c < 800; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      rob_stall = ($urandom_range(0, 3) == 0);
      fu_valid  = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        fu_pc[i]   = $urandom;
        fu_data[i] = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
